// File: rtl/wash_sense_timer.sv
// Purpose: debounces tub level switches, times wash/spin phases and watches fill duration for the washer controller.
// Latency: levels DEBOUNCE+1 edges after a raw change; timeouts WASH/SPIN_CYCLES edges after the phase starts; fault FILL_LIMIT+1 edges after fill starts.
// Backpressure: none; every input is sampled each cycle and every output is a level.
module wash_sense_timer #(
    parameter int WASH_CYCLES = 200,
    parameter int SPIN_CYCLES = 100,
    parameter int DEBOUNCE    = 4,
    parameter int FILL_LIMIT  = 1000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic level_full_raw,
    input  logic level_empty_raw,
    input  logic motor_on,
    input  logic fill_value_on,
    input  logic drain_value_on,
    input  logic soap_wash,
    input  logic water_wash,
    output logic filled,
    output logic drained,
    output logic cycle_timeout,
    output logic spin_timeout,
    output logic fault
);

    localparam int DB_W = $clog2(DEBOUNCE);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] WASH_LAST = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(FILL_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        WASH_RUN,
        WASH_DONE,
        SPIN_RUN,
        SPIN_DONE
    } state_t;

    // Channel 0 is the full switch, channel 1 the empty switch.
    logic [1:0]      raw_in;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [DB_W-1:0] deb_cnt [2];

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] phase_cnt_nxt;
    logic [CNT_W-1:0] wd_cnt;

    logic wash_cond;
    logic spin_cond;
    logic fill_cond;

    assign raw_in    = {level_empty_raw, level_full_raw};
    assign wash_cond = motor_on & (soap_wash | water_wash) & ~drain_value_on;
    assign spin_cond = motor_on & drain_value_on;

    // Full wins when both switches read high, so drained needs full clear.
    assign filled    = stable[0];
    assign drained   = stable[1] & ~stable[0];
    assign fill_cond = fill_value_on & ~filled;

    // Two-flop synchronizer plus debounce: accept a new level after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (deb_cnt[i] == DB_LAST) begin
                        stable[i]  <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Phase FSM state, counter and registered timeout decodes of the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            phase_cnt     <= '0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
        end else begin
            state         <= state_nxt;
            phase_cnt     <= phase_cnt_nxt;
            cycle_timeout <= (state_nxt == WASH_DONE);
            spin_timeout  <= (state_nxt == SPIN_DONE);
        end
    end

    // Next-state logic: a run aborts when its condition drops; a done state waits for the controller to move on.
    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        case (state)
            IDLE: begin
                if (wash_cond) begin
                    state_nxt     = WASH_RUN;
                    phase_cnt_nxt = '0;
                end else if (spin_cond) begin
                    state_nxt     = SPIN_RUN;
                    phase_cnt_nxt = '0;
                end
            end
            WASH_RUN: begin
                if (!wash_cond) begin
                    state_nxt     = IDLE;
                    phase_cnt_nxt = '0;
                end else if (phase_cnt == WASH_LAST) begin
                    state_nxt = WASH_DONE;
                end else begin
                    phase_cnt_nxt = phase_cnt + CNT_W'(1);
                end
            end
            WASH_DONE: begin
                if (spin_cond) begin
                    state_nxt     = SPIN_RUN;
                    phase_cnt_nxt = '0;
                end else if (!wash_cond) begin
                    state_nxt = IDLE;
                end
            end
            SPIN_RUN: begin
                if (!spin_cond) begin
                    state_nxt     = IDLE;
                    phase_cnt_nxt = '0;
                end else if (phase_cnt == SPIN_LAST) begin
                    state_nxt = SPIN_DONE;
                end else begin
                    phase_cnt_nxt = phase_cnt + CNT_W'(1);
                end
            end
            SPIN_DONE: begin
                if (!spin_cond) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt     = IDLE;
                phase_cnt_nxt = '0;
            end
        endcase
    end

    // Fill watchdog: count unfilled fill time, saturate at the limit, latch the fault once it is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            fault  <= 1'b0;
        end else begin
            if (fill_cond) begin
                if (wd_cnt != FILL_MAX) wd_cnt <= wd_cnt + CNT_W'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (wd_cnt == FILL_MAX) fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wash_sense_timer.sv
// Purpose: checks wash_sense_timer against an elapsed-time reference model plus directed literal expectations.
// Latency: outputs compared every falling edge, half a cycle after the active edge.
// Backpressure: none; stimulus changes on falling edges only.
module tb_wash_sense_timer;

    localparam int DB = 4;
    localparam int WC = 8;
    localparam int SC = 6;
    localparam int FL = 20;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    logic level_full_raw, level_empty_raw;
    logic motor_on, fill_value_on, drain_value_on, soap_wash, water_wash;
    logic filled, drained, cycle_timeout, spin_timeout, fault;

    int n_cmp = 0;
    int n_err = 0;

    wash_sense_timer #(
        .WASH_CYCLES(WC),
        .SPIN_CYCLES(SC),
        .DEBOUNCE   (DB),
        .FILL_LIMIT (FL),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .level_full_raw (level_full_raw),
        .level_empty_raw(level_empty_raw),
        .motor_on       (motor_on),
        .fill_value_on  (fill_value_on),
        .drain_value_on (drain_value_on),
        .soap_wash      (soap_wash),
        .water_wash     (water_wash),
        .filled         (filled),
        .drained        (drained),
        .cycle_timeout  (cycle_timeout),
        .spin_timeout   (spin_timeout),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Levels: raw value seen two edges late, accepted after DEBOUNCE disagreeing edges.
    // Phases: 0 none, 1 wash, 2 spin; el = edges spent in the phase counting the entry edge.
    bit m_hist1 [2];
    bit m_hist2 [2];
    bit m_stable[2];
    int m_run   [2];
    int ph = 0;
    int el = 0;
    int wd_run = 0;
    bit m_fault = 0;

    wire m_filled  = m_stable[0];
    wire m_drained = m_stable[1] & ~m_stable[0];
    wire m_ct      = (ph == 1) && (el > WC);
    wire m_st      = (ph == 2) && (el > SC);

    always @(posedge clk or negedge reset) begin
        bit wc, sc, fc;
        bit raw[2];
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_hist1[i] = 0; m_hist2[i] = 0; m_stable[i] = 0; m_run[i] = 0;
            end
            ph = 0; el = 0; wd_run = 0; m_fault = 0;
        end else begin
            wc = motor_on & (soap_wash | water_wash) & ~drain_value_on;
            sc = motor_on & drain_value_on;
            fc = fill_value_on & ~m_stable[0];
            raw[0] = level_full_raw;
            raw[1] = level_empty_raw;
            if (wd_run >= FL) m_fault = 1;
            wd_run = fc ? ((wd_run < FL) ? wd_run + 1 : FL) : 0;
            for (int i = 0; i < 2; i++) begin
                if (m_hist2[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_stable[i] = m_hist2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_hist2[i] = m_hist1[i];
                m_hist1[i] = raw[i];
            end
            if (ph == 0) begin
                if (wc) begin ph = 1; el = 1; end
                else if (sc) begin ph = 2; el = 1; end
            end else if (ph == 1) begin
                if (el > WC) begin
                    if (sc) begin ph = 2; el = 1; end
                    else if (!wc) ph = 0;
                end else if (!wc) ph = 0;
                else el++;
            end else begin
                if (el > SC) begin
                    if (!sc) ph = 0;
                end else if (!sc) ph = 0;
                else el++;
            end
        end
    end

    // Every falling edge: DUT outputs against the model.
    always @(negedge clk) begin
        check("filled",        filled,        m_filled);
        check("drained",       drained,       m_drained);
        check("cycle_timeout", cycle_timeout, m_ct);
        check("spin_timeout",  spin_timeout,  m_st);
        check("fault",         fault,         m_fault);
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_filled"},  filled,        1'b0);
        check({tag, "_drained"}, drained,       1'b0);
        check({tag, "_ct"},      cycle_timeout, 1'b0);
        check({tag, "_st"},      spin_timeout,  1'b0);
        check({tag, "_fault"},   fault,         1'b0);
    endtask

    initial begin
        reset = 1'b0;
        level_full_raw = 0; level_empty_raw = 0;
        motor_on = 0; fill_value_on = 0; drain_value_on = 0; soap_wash = 0; water_wash = 0;

        // Reset state
        wait_n(2);
        check_all_zero("reset");
        #2 reset = 1'b1;

        // Empty-switch glitch of two cycles is ignored
        @(negedge clk);
        level_empty_raw = 1; wait_n(2); level_empty_raw = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("glitch_drained", drained, 1'b0);
        end

        // Empty switch held: drained after edge k+5
        level_empty_raw = 1;
        wait_n(5); check("empty_k4", drained, 1'b0);
        wait_n(1); check("empty_k5", drained, 1'b1);

        // Full switch held: filled after edge k+5, full overrides empty
        level_full_raw = 1;
        wait_n(5); check("full_k4", filled, 1'b0);
        wait_n(1); check("full_k5", filled, 1'b1);
        check("full_drained", drained, 1'b0);

        // Wash timeout after 8 edges, falls on the edge after soap drops
        motor_on = 1; soap_wash = 1;
        wait_n(8); check("wash_k7", cycle_timeout, 1'b0);
        wait_n(1); check("wash_k8", cycle_timeout, 1'b1);
        soap_wash = 0;
        wait_n(1); check("wash_drop", cycle_timeout, 1'b0);

        // Wash straight into spin
        soap_wash = 1;
        wait_n(9); check("w2s_wash", cycle_timeout, 1'b1);
        drain_value_on = 1;
        wait_n(1); check("w2s_ct_fall", cycle_timeout, 1'b0);
        wait_n(5); check("w2s_e5", spin_timeout, 1'b0);
        wait_n(1); check("w2s_e6", spin_timeout, 1'b1);
        motor_on = 0;
        wait_n(1); check("spin_drop", spin_timeout, 1'b0);
        soap_wash = 0; drain_value_on = 0;
        wait_n(2);

        // Aborted wash then full re-time
        motor_on = 1; soap_wash = 1;
        wait_n(5); soap_wash = 0;
        wait_n(2); check("abort_ct", cycle_timeout, 1'b0);
        soap_wash = 1;
        wait_n(8); check("retime_k7", cycle_timeout, 1'b0);
        wait_n(1); check("retime_k8", cycle_timeout, 1'b1);
        motor_on = 0; soap_wash = 0;

        // Fill that completes in time never faults
        level_full_raw = 0; wait_n(8);
        check("unfilled", filled, 1'b0);
        fill_value_on = 1;
        wait_n(10); level_full_raw = 1;
        wait_n(15); check("fill_ok_fault", fault, 1'b0);
        check("fill_ok_filled", filled, 1'b1);
        fill_value_on = 0; level_full_raw = 0;
        wait_n(8);

        // Stuck fill: fault after 21 edges, sticky
        fill_value_on = 1;
        wait_n(20); check("wd_k19", fault, 1'b0);
        wait_n(1);  check("wd_k20", fault, 1'b1);
        fill_value_on = 0;
        wait_n(3);  check("wd_sticky", fault, 1'b1);

        // Reset during spin drops everything at once; spin re-times from zero
        motor_on = 1; drain_value_on = 1;
        wait_n(3);
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        #2 reset = 1'b1;
        wait_n(6); check("rst_spin_k5", spin_timeout, 1'b0);
        wait_n(1); check("rst_spin_k6", spin_timeout, 1'b1);
        motor_on = 0; drain_value_on = 0;

        // Randomized activity checked by the model on every cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            case ($urandom_range(0, 39))
                0: motor_on        = ~motor_on;
                1: soap_wash       = ~soap_wash;
                2: water_wash      = ~water_wash;
                3: drain_value_on  = ~drain_value_on;
                4: fill_value_on   = ~fill_value_on;
                5: level_full_raw  = ~level_full_raw;
                6: level_empty_raw = ~level_empty_raw;
                default: ;
            endcase
        end

        wait_n(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wash_sense_timer.md
# wash_sense_timer

Sensor-conditioning and phase-timing stage feeding `automatic_washing_machine`. It generates that controller's `filled`, `drained`, `cycle_timeout` and `spin_timeout` inputs:
- level outputs come from debounced raw float-switch inputs;
- timeouts come from cycle counters gated by the controller's own actuator outputs.

It also provides a sticky fill-watchdog fault.

## Interface
- `WASH_CYCLES`, default 200: clock cycles of wash agitation before `cycle_timeout`; must be ≥ 2 and < 2^CNT_W.
- `SPIN_CYCLES`, default 100: clock cycles of spin before `spin_timeout`; must be ≥ 2 and < 2^CNT_W.
- `DEBOUNCE`, default 4: consecutive stable cycles required to accept a level-switch change; must be ≥ 2.
- `FILL_LIMIT`, default 1000: maximum cycles `fill_value_on` may stay high without `filled` before a fault; must be < 2^CNT_W.
- `CNT_W`, default 16: width of the phase and watchdog counters.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `level_full_raw` input, 1 bit: raw, asynchronous "tub full" switch.
- `level_empty_raw` input, 1 bit: raw, asynchronous "tub empty" switch.
- `motor_on` input, 1 bit: from the controller.
- `fill_value_on` input, 1 bit: from the controller.
- `drain_value_on` input, 1 bit: from the controller.
- `soap_wash` input, 1 bit: from the controller.
- `water_wash` input, 1 bit: from the controller.
- `filled` output, 1 bit: debounced full level.
- `drained` output, 1 bit: debounced empty level, and not full.
- `cycle_timeout` output, 1 bit: wash phase time elapsed.
- `spin_timeout` output, 1 bit: spin phase time elapsed.
- `fault` output, 1 bit: sticky fill-watchdog fault.

## Operation
**Level conditioning** (one identical channel per raw input):
- 2-flop synchronizer, then a debounce counter against the stable value.
- If synced ≠ stable: counter increments. When the counter equals DEBOUNCE-1, stable takes the synced value and the counter clears.
- If synced = stable: the counter clears.
- `filled` = stable_full.
- `drained` = stable_empty & ~stable_full. Both switches stable high is treated as full.

**Phase timer FSM** (states IDLE, WASH_RUN, WASH_DONE, SPIN_RUN, SPIN_DONE):
- Conditions:
  - wash_cond = `motor_on` & (`soap_wash` | `water_wash`) & ~`drain_value_on`
  - spin_cond = `motor_on` & `drain_value_on`
  - The two conditions are mutually exclusive by construction.
- IDLE: on wash_cond go to WASH_RUN; on spin_cond go to SPIN_RUN. The counter loads 0 on either entry.
- WASH_RUN: counter +1 per cycle. When counter == WASH_CYCLES-1, go to WASH_DONE. If wash_cond drops, go to IDLE and clear the counter (abort, no timeout).
- WASH_DONE: `cycle_timeout`=1. If spin_cond, go to SPIN_RUN (counter 0). Else if ~wash_cond, go to IDLE.
- SPIN_RUN and SPIN_DONE: same as the wash states, using SPIN_CYCLES and `spin_timeout`. SPIN_DONE exits to IDLE on ~spin_cond.
- `cycle_timeout` and `spin_timeout` are registered state decodes and are never both high.

**Fill watchdog:**
- Counter increments while `fill_value_on` & ~`filled`; it clears otherwise.
- When it reaches FILL_LIMIT, `fault` sets. `fault` holds until reset and has no effect on the other outputs.

## Timing
- **Reset values** (asynchronous assert, all outputs 0): `filled`, `drained`, `cycle_timeout`, `spin_timeout`, `fault`. FSM in IDLE; all counters and synchronizers 0.
- **Release:** the first active edge after `reset` rises starts normal operation.
- **Debounce latency:** if a raw input holds a new value from edge k, the output changes after edge k+DEBOUNCE+1. Pulses shorter than DEBOUNCE synced cycles are ignored.
- **Timer latency:** if wash_cond is first sampled high at edge k, `cycle_timeout` rises after edge k+WASH_CYCLES. It falls on the edge after wash_cond drops, or on the edge that enters SPIN_RUN. The same rule applies to spin.
- **Watchdog:** `fault` rises after the edge at which the counter first equals FILL_LIMIT, i.e. FILL_LIMIT+1 edges after the fill condition begins.
- **Reset mid-phase:** outputs drop immediately with no partial-count retention. On release, timers restart from 0.
- **Counters:** saturate, never wrap. The phase counter is bounded by the FSM; the watchdog counter stops at FILL_LIMIT.

## Test plan
Bench settings: DEBOUNCE=4, WASH_CYCLES=8, SPIN_CYCLES=6, FILL_LIMIT=20.
- **Reset and debounce:** hold `reset`=0 for 2 cycles → all outputs 0. Set `level_full_raw`=1 from edge k → `filled`=1 after edge k+5. A 2-cycle glitch on `level_empty_raw` → `drained` stays 0.
- **Wash timeout:** `motor_on`=1, `soap_wash`=1 sampled at edge k → `cycle_timeout` rises after edge k+8. Drop `soap_wash` → `cycle_timeout` falls on the next edge.
- **Wash to spin:** in WASH_DONE, set `drain_value_on`=1 → `cycle_timeout` falls and the spin count starts. `spin_timeout` rises 6 edges later. Drop `motor_on` → `spin_timeout` falls.
- **Aborted wash:** drop wash_cond after 5 cycles → no timeout. Re-assert → a full 8 cycles are needed again.
- **Watchdog:** `fill_value_on`=1 with `filled`=0 → `fault` rises after 21 edges and stays high after `fill_value_on` drops. A fill that completes at cycle 15 → no fault.
- **Mid-operation reset:** assert `reset` during SPIN_RUN → all outputs 0 immediately. After release, spin re-times a full 6 cycles.
